// File: rtl/decode_exec_queue.sv
// decode_exec_queue: decode->execute packet FIFO with occupancy, almost-full and flush.
// Define DEC_EXEC_QUEUE_BYPASS_EN for a zero-latency path through an empty queue.
module decode_exec_queue #(
  parameter int PKT_W = 256,
  parameter int DEPTH = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PKT_W-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PKT_W-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW:0] rd_ptr, wr_ptr, count_nx;
  logic empty, full, push, pop, wr_en, rd_en;
  assign empty = rd_ptr == wr_ptr;
  assign full = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign in_ready = reset_n && !full;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
`ifdef DEC_EXEC_QUEUE_BYPASS_EN
  logic byp;
  assign byp = empty && push && !flush;
  assign out_valid = !empty || byp;
  assign out_data = empty ? in_data : mem[rd_ptr[AW-1:0]];
  // a bypassed packet consumed in the same cycle never touches storage
  assign wr_en = push && !flush && !(byp && out_ready);
`else
  assign out_valid = !empty;
  assign out_data = mem[rd_ptr[AW-1:0]];
  assign wr_en = push && !flush;
`endif
  assign rd_en = pop && !empty && !flush;
  assign count_nx = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      almost_full <= 1'b0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count <= '0;
      almost_full <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      almost_full <= count_nx >= AF_TH;
    end
  end
  a_in_stable: assert property (@(posedge clk) disable iff (!reset_n)
    in_valid && !in_ready |=> $stable(in_data));
  a_count_max: assert property (@(posedge clk) count <= DEPTH_C);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
    rd_en |-> count != '0);
endmodule

// File: tb/tb_decode_exec_queue.sv
// tb_decode_exec_queue: directed checks of the decode->execute queue (DEPTH=4, AF_MARGIN=1).
module tb_decode_exec_queue;
  localparam int W = 32;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0, out_data;
  logic in_ready, out_valid, almost_full;
  logic [2:0] count;
  int total = 0, bad = 0;
  decode_exec_queue #(.PKT_W(W), .DEPTH(4), .AF_MARGIN(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset_n = 0;
    tick;
    tick;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b want=0", almost_full); end
    reset_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = 32'hA000_0000 + i;
      tick;
      total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); end
      total++; if (almost_full !== (i + 1 >= 3)) begin bad++; $display("FAIL fill_af[%0d] got=%b want=%b", i, almost_full, i + 1 >= 3); end
      total++; if (in_ready !== (i + 1 < 4)) begin bad++; $display("FAIL fill_in_ready[%0d] got=%b want=%b", i, in_ready, i + 1 < 4); end
    end
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, out_valid); end
      total++; if (out_data !== 32'hA000_0000 + i) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, out_data, 32'hA000_0000 + i); end
      tick;
      total++; if (count !== 3'(3 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d want=%0d", i, count, 3 - i); end
    end
    out_ready = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", out_valid); end
  endtask
  task automatic test_stream;
    out_ready = 1;
    for (int c = 0; c <= 10; c++) begin
      in_valid = c < 10;
      in_data = 32'hB000_0000 + c;
      #1;
      total++; if (out_valid !== (c > 0)) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=%b", c, out_valid, c > 0); end
      if (c > 0) begin
        total++; if (out_data !== 32'hB000_0000 + c - 1) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", c, out_data, 32'hB000_0000 + c - 1); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", c, count); end
      end
      tick;
    end
    in_valid = 0;
    out_ready = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL stream_end_count got=%0d want=0", count); end
  endtask
  task automatic test_push_pop;
    in_valid = 1;
    in_data = 32'hC000_0000;
    tick;
    in_data = 32'hC000_0001;
    tick;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL pp_pre_count got=%0d want=2", count); end
    in_data = 32'hC000_0002;
    out_ready = 1;
    #1;
    total++; if (out_data !== 32'hC000_0000) begin bad++; $display("FAIL pp_head0 got=%h want=c0000000", out_data); end
    tick;
    in_valid = 0;
    out_ready = 0;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL pp_count got=%0d want=2", count); end
    total++; if (out_data !== 32'hC000_0001) begin bad++; $display("FAIL pp_head1 got=%h want=c0000001", out_data); end
  endtask
  task automatic test_flush;
    in_valid = 1;
    in_data = 32'hC000_0003;
    tick;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fl_pre_count got=%0d want=3", count); end
    flush = 1;
    in_data = 32'hDEAD_0004;
    tick;
    flush = 0;
    in_valid = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fl_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b want=0", out_valid); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL fl_af got=%b want=0", almost_full); end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_stay_empty got=%b want=0", out_valid); end
    in_valid = 1;
    in_data = 32'hC000_0005;
    tick;
    in_valid = 0;
    total++; if (out_data !== 32'hC000_0005) begin bad++; $display("FAIL fl_next_head got=%h want=c0000005", out_data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL fl_next_count got=%0d want=1", count); end
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = 32'hE000_0000 + i;
      tick;
    end
    in_valid = 0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL rm_full_count got=%0d want=4", count); end
    reset_n = 0;
    tick;
    reset_n = 1;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rm_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%b want=1", in_ready); end
  endtask
  task automatic test_bypass;
`ifdef DEC_EXEC_QUEUE_BYPASS_EN
    in_valid = 1;
    out_ready = 1;
    in_data = 32'hF000_0001;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 32'hF000_0001) begin bad++; $display("FAIL byp_data got=%h want=f0000001", out_data); end
    tick;
    in_valid = 0;
    out_ready = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL byp_count got=%0d want=0", count); end
`endif
  endtask
  initial begin
    test_reset;
    test_fill_drain;
    test_stream;
    test_push_pop;
    test_flush;
    test_reset_mid;
    test_bypass;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
